// File: rtl/fabric_reset_sequencer.sv
// Fabric reset sequencer: releases core, camera (with SCCB handshake) and LCD resets in order.
// Defining RST_SEQ_TIMEOUT_EN adds the CAM_CFG timeout / retry / ERROR path.
module fabric_reset_sequencer #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CORE_DELAY    = 1000,
    parameter int unsigned CAM_TIMEOUT   = 2500000,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned LCD_DELAY     = 256
) (
    input  logic       CLK_BASE,
    input  logic       RESET,
    input  logic       INIT_DONE,
    input  logic       MSS_HPMS_READY,
    input  logic       CAM_CFG_DONE,
    output logic       CORE_RESET_N,
    output logic       CAM_RESET_N,
    output logic       CAM_CFG_START,
    output logic       LCD_RESET_N,
    output logic       SYS_READY,
    output logic       SEQ_ERROR,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STABLE    = 3'd1,
        CORE_WAIT = 3'd2,
        CAM_CFG   = 3'd3,
        CAM_RETRY = 3'd4,
        LCD_WAIT  = 3'd5,
        RUN       = 3'd6,
        ERROR     = 3'd7
    } state_t;

    logic [1:0]  init_sync;
    logic [1:0]  ready_sync;
    logic        rdy;
    state_t      state;
    state_t      nxt;
    logic [31:0] cnt;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int          RETRY_W    = $clog2(MAX_RETRY + 2);
    localparam logic [31:0] RETRY_HOLD = 32'd16;
    logic [RETRY_W-1:0] retry_cnt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            init_sync  <= '0;
            ready_sync <= '0;
        end else begin
            init_sync  <= {init_sync[0], INIT_DONE};
            ready_sync <= {ready_sync[0], MSS_HPMS_READY};
        end
    end

    assign rdy = init_sync[1] & ready_sync[1];

    // NOTE: nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        nxt = state;
        if (!rdy) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:      nxt = STABLE;
                STABLE:    if (cnt == STABLE_CYCLES - 1) nxt = CORE_WAIT;
                CORE_WAIT: if (cnt == CORE_DELAY - 1) nxt = CAM_CFG;
                CAM_CFG: begin
                    // DONE is tested first so it wins a same-cycle timeout.
                    if (CAM_CFG_DONE) nxt = LCD_WAIT;
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt == CAM_TIMEOUT - 1)
                        nxt = (retry_cnt < RETRY_W'(MAX_RETRY)) ? CAM_RETRY : ERROR;
`endif
                end
`ifdef RST_SEQ_TIMEOUT_EN
                CAM_RETRY: if (cnt == RETRY_HOLD - 1) nxt = CAM_CFG;
                ERROR:     nxt = ERROR;
`else
                CAM_RETRY: nxt = IDLE;
                ERROR:     nxt = IDLE;
`endif
                LCD_WAIT:  if (cnt == LCD_DELAY - 1) nxt = RUN;
                RUN:       nxt = RUN;
                default:   nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from nxt so they move on the same edge as STATE.
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            CORE_RESET_N  <= 1'b0;
            CAM_RESET_N   <= 1'b0;
            CAM_CFG_START <= 1'b0;
            LCD_RESET_N   <= 1'b0;
            SYS_READY     <= 1'b0;
        end else begin
            state         <= nxt;
            cnt           <= (nxt != state) ? '0 : cnt + 32'd1;
            CORE_RESET_N  <= (nxt != IDLE) && (nxt != STABLE);
            CAM_RESET_N   <= nxt inside {CAM_CFG, LCD_WAIT, RUN};
            CAM_CFG_START <= (nxt == CAM_CFG) && (state != CAM_CFG);
            LCD_RESET_N   <= (nxt == RUN);
            SYS_READY     <= (nxt == RUN);
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            retry_cnt <= '0;
            SEQ_ERROR <= 1'b0;
        end else begin
            if (nxt == IDLE)
                retry_cnt <= '0;
            else if (state == CAM_RETRY && nxt == CAM_CFG)
                retry_cnt <= retry_cnt + RETRY_W'(1);
            SEQ_ERROR <= (nxt == ERROR);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = |{CAM_TIMEOUT, MAX_RETRY};
    assign SEQ_ERROR  = 1'b0;
`endif

    assign STATE = state;

endmodule
